core7_dct_arbiter: RTL and testbench
====================================

# core7_dct_arbiter

Round-robin arbiter that shares a single data-trace capture sink between the seven Nios II cores of the Core7 system. Each core's OCI presents a flushed data-trace word (30-bit compressed trace buffer plus 4-bit fill count). The arbiter grants one core per cycle, registers the word with a core tag toward the sink, and sequences end-of-test draining so that `test_has_ended` asserts only after all trace is delivered.

## Interface
- `NUM_REQ`, 7, number of requesting cores (2..8)
- `ID_W`, 3, width of core tag; must satisfy 2^ID_W >= NUM_REQ
- `DATA_W`, 30, trace buffer width
- `CNT_W`, 4, trace fill-count width
- `clk`  in  1  sole clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-core word-valid
- `req_buffer`  in  NUM_REQ*DATA_W  per-core trace word; core i at bits [i*DATA_W +: DATA_W]
- `req_count`  in  NUM_REQ*CNT_W  per-core fill count; core i at [i*CNT_W +: CNT_W]
- `req_ack`  out  NUM_REQ  one-hot accept strobe (combinational)
- `tr_valid`  out  1  output word valid
- `tr_data`  out  DATA_W  granted trace word
- `tr_count`  out  CNT_W  granted fill count
- `tr_core`  out  ID_W  index of granted core
- `tr_ready`  in  1  sink accepts output word
- `test_ending`  in  1  level; request end-of-test drain
- `test_has_ended`  out  1  drain complete
- `drop_count`  out  8  saturating count of discarded zero-count words

## Operation
- Output register: single stage holding `tr_data/tr_count/tr_core`, `tr_valid` flag. Register is "free" when `tr_valid`=0 or (`tr_valid` & `tr_ready`).
- Arbitration: when enabled and any `req` set, winner = first set `req` searching from `last+1` upward, wrapping modulo NUM_REQ. `last` updates to winner on every accept (forwarded or dropped).
- Accept: `req_ack[winner]`=1 in the same cycle; requester treats `req & req_ack` as transfer. At most one `req_ack` bit high per cycle.
- Zero-count word (`req_count`=0): accepted and acked even when output register not free; not forwarded; `drop_count` increments, saturating at 255. Does not disturb the output register.
- Nonzero word: accepted only when register free; loads register, `tr_valid`=1 next cycle.
- If register not free and winner's count is nonzero, no ack, `last` unchanged.
- Sink handshake: transfer on `tr_valid & tr_ready`; `tr_valid` falls next cycle unless a new word is loaded that cycle. Output fields stable while `tr_valid & !tr_ready`.
- FSM states:
  - RUN: arbitration enabled. `test_ending`=1 -> DRAIN.
  - DRAIN: arbitration enabled. When `req`=0 and output register empty (`tr_valid`=0) in the same cycle -> ENDED.
  - ENDED: arbitration disabled, `req_ack`=0, `test_has_ended`=1. Held until reset; `test_ending` deassertion ignored.
- Requesters that never stop requesting keep DRAIN active indefinitely; by design.

## Timing
- Reset values: `tr_valid`=0, `tr_data`=0, `tr_count`=0, `tr_core`=0, `test_has_ended`=0, `drop_count`=0, `last`=NUM_REQ-1 (core 0 has first priority), FSM=RUN. `req_ack` is 0 during reset.
- Latency: `req` accepted in cycle N -> `tr_valid` at N+1.
- Throughput: one word per cycle with `tr_ready` held high (load and unload in the same cycle).
- `test_ending` sampled at rising edge; RUN->DRAIN takes 1 cycle; ENDED entered the cycle after the empty condition; `test_has_ended` registered.
- Reset mid-operation: held word and drop count discarded immediately (asynchronous).

## Test plan
- All 7 `req` high, counts 5, `tr_ready`=1 -> acks to cores 0,1,...,6,0 on consecutive cycles; `tr_core` follows one cycle later.
- Cores 2 and 5 requesting, `tr_ready`=0 -> core 2 acked once, `tr_valid`=1 with data held; no further acks until `tr_ready`=1, then core 5 next.
- Core 3 `req_count`=0 for 300 words -> each acked, `tr_valid` stays 0, `drop_count` saturates at 255.
- One held word, `test_ending`=1, `tr_ready`=0 for 4 cycles then 1 -> `test_has_ended` rises 1 cycle after sink transfer; later `req` gets no ack.
- Reset asserted while `tr_valid`=1 -> all outputs zero immediately; after release core 0 granted first.

Source files
------------

// File: rtl/core7_dct_arbiter.sv
// Round-robin arbiter sharing one data-trace capture sink among the Core7 Nios II cores.
// Zero-count words are acknowledged and discarded; end-of-test drain sequencing drives test_has_ended.
module core7_dct_arbiter #(
   parameter int unsigned NUM_REQ = 7,
   parameter int unsigned ID_W    = 3,
   parameter int unsigned DATA_W  = 30,
   parameter int unsigned CNT_W   = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_buffer,
   input  logic [NUM_REQ*CNT_W-1:0]  req_count,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic                      tr_valid,
   output logic [DATA_W-1:0]         tr_data,
   output logic [CNT_W-1:0]          tr_count,
   output logic [ID_W-1:0]           tr_core,
   input  logic                      tr_ready,
   input  logic                      test_ending,
   output logic                      test_has_ended,
   output logic [7:0]                drop_count
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ENDED} state_e;

   state_e             state_q, state_d;
   logic [ID_W-1:0]    last_q, last_d;
   logic               valid_q, valid_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [ID_W-1:0]    core_q, core_d;
   logic [7:0]         drop_q, drop_d;
   logic               ended_q, ended_d;

   logic               found;
   logic [ID_W-1:0]    winner;
   logic [DATA_W-1:0]  win_data;
   logic [CNT_W-1:0]   win_cnt;
   logic               reg_free;
   logic               arb_en;
   logic               accept;
   logic               win_zero;
   logic               load;
   int unsigned        pos;

   // Search starts just past the last accepted core and wraps modulo NUM_REQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      pos    = 0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         pos = int'(last_q) + i;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         if (!found && req[ID_W'(pos)]) begin
            found  = 1'b1;
            winner = ID_W'(pos);
         end
      end
   end

   always_comb begin
      win_data = '0;
      win_cnt  = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (winner == ID_W'(j)) begin
            win_data = req_buffer[j*DATA_W +: DATA_W];
            win_cnt  = req_count[j*CNT_W +: CNT_W];
         end
      end
   end

   always_comb begin
      reg_free = !valid_q || tr_ready;
      arb_en   = (state_q != ST_ENDED) && reset_n;
      win_zero = (win_cnt == '0);
      accept   = arb_en && found && (win_zero || reg_free);
      load     = accept && !win_zero;

      req_ack = '0;
      if (accept) req_ack[winner] = 1'b1;

      last_d  = accept ? winner : last_q;
      data_d  = load ? win_data : data_q;
      count_d = load ? win_cnt  : count_q;
      core_d  = load ? winner   : core_q;

      valid_d = valid_q;
      if (load)                     valid_d = 1'b1;
      else if (valid_q && tr_ready) valid_d = 1'b0;

      drop_d = drop_q;
      if (accept && win_zero && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

      state_d = state_q;
      case (state_q)
         ST_RUN:   if (test_ending) state_d = ST_DRAIN;
         ST_DRAIN: if ((req == '0) && !valid_q) state_d = ST_ENDED;
         default:  state_d = ST_ENDED;
      endcase
      ended_d = (state_d == ST_ENDED);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         last_q  <= ID_W'(NUM_REQ - 1);
         valid_q <= 1'b0;
         data_q  <= '0;
         count_q <= '0;
         core_q  <= '0;
         drop_q  <= '0;
         ended_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         count_q <= count_d;
         core_q  <= core_d;
         drop_q  <= drop_d;
         ended_q <= ended_d;
      end
   end

   assign tr_valid       = valid_q;
   assign tr_data        = data_q;
   assign tr_count       = count_q;
   assign tr_core        = core_q;
   assign drop_count     = drop_q;
   assign test_has_ended = ended_q;

endmodule

// File: tb/tb_core7_dct_arbiter.sv
// Directed bench for core7_dct_arbiter: round-robin order, back-pressure, drops, drain, async reset.
module tb_core7_dct_arbiter;

   localparam int unsigned N  = 7;
   localparam int unsigned DW = 30;
   localparam int unsigned CW = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [N-1:0]      req;
   logic [N*DW-1:0]   req_buffer;
   logic [N*CW-1:0]   req_count;
   logic [N-1:0]      req_ack;
   logic              tr_valid;
   logic [DW-1:0]     tr_data;
   logic [CW-1:0]     tr_count;
   logic [2:0]        tr_core;
   logic              tr_ready;
   logic              test_ending;
   logic              test_has_ended;
   logic [7:0]        drop_count;

   logic [DW-1:0]     dat [N];
   logic [CW-1:0]     cnt [N];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always_comb begin
      req_buffer = '0;
      req_count  = '0;
      for (int i = 0; i < N; i++) begin
         req_buffer[i*DW +: DW] = dat[i];
         req_count[i*CW +: CW]  = cnt[i];
      end
   end

   core7_dct_arbiter #(.NUM_REQ(N), .ID_W(3), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_buffer(req_buffer),
      .req_count(req_count), .req_ack(req_ack), .tr_valid(tr_valid),
      .tr_data(tr_data), .tr_count(tr_count), .tr_core(tr_core),
      .tr_ready(tr_ready), .test_ending(test_ending),
      .test_has_ended(test_has_ended), .drop_count(drop_count)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      req         = '1;
      tr_ready    = 1'b0;
      test_ending = 1'b0;
      for (int i = 0; i < N; i++) begin
         dat[i] = 30'h100 + 30'(i);
         cnt[i] = 4'd5;
      end
      #2;
      chk("rst_ack",   32'(req_ack), 32'h0);
      chk("rst_valid", 32'(tr_valid), 32'h0);
      chk("rst_data",  32'(tr_data), 32'h0);
      chk("rst_count", 32'(tr_count), 32'h0);
      chk("rst_core",  32'(tr_core), 32'h0);
      chk("rst_ended", 32'(test_has_ended), 32'h0);
      chk("rst_drop",  32'(drop_count), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      req     = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Full rotation with the sink always ready.
      do_reset();
      req = '1;
      tr_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #4;
         chk("rr_ack", 32'(req_ack), 32'(1) << (k % 7));
         if (k > 0) begin
            chk("rr_core",  32'(tr_core), 32'((k - 1) % 7));
            chk("rr_data",  32'(tr_data), 32'h100 + 32'((k - 1) % 7));
            chk("rr_valid", 32'(tr_valid), 32'h1);
         end
         step();
      end

      // Back-pressure: cores 2 and 5.
      do_reset();
      req = 7'b0100100;
      #4;
      chk("bp_ack0", 32'(req_ack), 32'h04);
      step();
      for (int k = 0; k < 3; k++) begin
         #4;
         chk("bp_hold_ack",   32'(req_ack), 32'h0);
         chk("bp_hold_valid", 32'(tr_valid), 32'h1);
         chk("bp_hold_core",  32'(tr_core), 32'h2);
         chk("bp_hold_data",  32'(tr_data), 32'h102);
         chk("bp_hold_count", 32'(tr_count), 32'h5);
         step();
      end
      tr_ready = 1'b1;
      #4;
      chk("bp_ack5", 32'(req_ack), 32'h20);
      step();
      #4;
      chk("bp_core5", 32'(tr_core), 32'h5);
      chk("bp_data5", 32'(tr_data), 32'h105);
      chk("bp_ack2b", 32'(req_ack), 32'h04);
      step();

      // Zero-count word accepted while the output register is full.
      do_reset();
      cnt[1] = 4'd7;
      req = 7'b0000010;
      #4;
      chk("zf_ack1", 32'(req_ack), 32'h02);
      step();
      cnt[4] = 4'd0;
      req = 7'b0010000;
      #4;
      chk("zf_ack4",  32'(req_ack), 32'h10);
      chk("zf_count", 32'(tr_count), 32'h7);
      step();
      req = '0;
      #4;
      chk("zf_drop",  32'(drop_count), 32'h1);
      chk("zf_core",  32'(tr_core), 32'h1);
      chk("zf_valid", 32'(tr_valid), 32'h1);
      step();

      // 300 zero-count words from core 3: drop counter saturates.
      do_reset();
      cnt[3] = 4'd0;
      req = 7'b0001000;
      tr_ready = 1'b1;
      for (int k = 0; k < 300; k++) begin
         #4;
         chk("sat_ack", 32'(req_ack), 32'h08);
         if (k == 254) chk("sat_drop254", 32'(drop_count), 32'd254);
         step();
      end
      req = '0;
      #4;
      chk("sat_drop",  32'(drop_count), 32'd255);
      chk("sat_valid", 32'(tr_valid), 32'h0);
      step();

      // End-of-test drain with one held word.
      do_reset();
      req = 7'b0000001;
      #4;
      chk("dr_ack0", 32'(req_ack), 32'h01);
      step();
      req = '0;
      test_ending = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #4;
         chk("dr_valid", 32'(tr_valid), 32'h1);
         chk("dr_ended", 32'(test_has_ended), 32'h0);
         step();
      end
      tr_ready = 1'b1;
      #4;
      chk("dr_xfer_ended", 32'(test_has_ended), 32'h0);
      step();
      #4;
      chk("dr_empty_valid", 32'(tr_valid), 32'h0);
      chk("dr_empty_ended", 32'(test_has_ended), 32'h0);
      step();
      #4;
      chk("dr_ended_now", 32'(test_has_ended), 32'h1);
      test_ending = 1'b0;
      req = '1;
      #1;
      chk("dr_late_ack", 32'(req_ack), 32'h0);
      step();
      #4;
      chk("dr_ended_held", 32'(test_has_ended), 32'h1);
      chk("dr_late_valid", 32'(tr_valid), 32'h0);
      step();

      // Asynchronous reset while a word is held.
      do_reset();
      cnt[1] = 4'd0;
      cnt[3] = 4'd9;
      req = 7'b0000010;
      #4;
      chk("ar_ack1", 32'(req_ack), 32'h02);
      step();
      req = 7'b0001000;
      #4;
      chk("ar_ack3", 32'(req_ack), 32'h08);
      step();
      #2;
      chk("ar_pre_valid", 32'(tr_valid), 32'h1);
      chk("ar_pre_core",  32'(tr_core), 32'h3);
      chk("ar_pre_drop",  32'(drop_count), 32'h1);
      reset_n = 1'b0;
      #1;
      chk("ar_valid", 32'(tr_valid), 32'h0);
      chk("ar_data",  32'(tr_data), 32'h0);
      chk("ar_count", 32'(tr_count), 32'h0);
      chk("ar_core",  32'(tr_core), 32'h0);
      chk("ar_drop",  32'(drop_count), 32'h0);
      chk("ar_ack",   32'(req_ack), 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < N; i++) cnt[i] = 4'd5;
      req = '1;
      #4;
      chk("ar_first_ack", 32'(req_ack), 32'h01);
      step();
      #4;
      chk("ar_first_core",  32'(tr_core), 32'h0);
      chk("ar_first_valid", 32'(tr_valid), 32'h1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
